// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester GPIO bus arbiter.
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Round-robin pointer after reset: "last granted" = m1, so m0 wins first.
  localparam logic RR_RESET_LAST = 1'b1;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the GPIO slave.
// modport master: the arbiter's view (it masters the GPIO slave bus).
// modport slave:  the environment's view (requesters plus GPIO slave).
interface gpio_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_wr;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_wr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          s_cs;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;

  modport master (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output s_cs, s_wr, s_addr, s_wdata,
    input  s_rdata
  );

  modport slave (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  s_cs, s_wr, s_addr, s_wdata,
    output s_rdata
  );

endinterface

// File: rtl/gpio_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Lone requester wins; on contention the one not granted last time wins.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one GPIO slave between two requesters.
// Each transaction: IDLE (grant + latch) -> ACCESS (one slave cycle) -> DONE (ack).
module gpio_bus_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  gpio_bus_arbiter_if.master  bus
);

  state_t        state, state_nxt;
  logic          last;
  logic          gnt_idx;
  logic          lat_wr;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] rdata0, rdata1;

  logic          pick_valid;
  logic          pick_idx;
  logic          grant;

  rr_pick2 u_pick (
    .req       ({bus.m1_req, bus.m0_req}),
    .last      (last),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  assign grant = (state == IDLE) && pick_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: one ACCESS cycle and one DONE cycle per grant.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request at the grant; later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= RR_RESET_LAST;
      gnt_idx   <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant) begin
      last      <= pick_idx;
      gnt_idx   <= pick_idx;
      lat_wr    <= pick_idx ? bus.m1_wr    : bus.m0_wr;
      lat_addr  <= pick_idx ? bus.m1_addr  : bus.m0_addr;
      lat_wdata <= pick_idx ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  // Capture slave read data at the end of ACCESS into the granted requester's register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS && !lat_wr) begin
      if (gnt_idx) rdata1 <= bus.s_rdata;
      else         rdata0 <= bus.s_rdata;
    end
  end

  // Slave strobes only in ACCESS; address/data hold the latched values.
  // Acks are masked by reset so a transaction killed in DONE never acks.
  always_comb begin
    bus.s_cs     = (state == ACCESS);
    bus.s_wr     = (state == ACCESS) && lat_wr;
    bus.s_addr   = lat_addr;
    bus.s_wdata  = lat_wdata;
    bus.m0_ack   = (state == DONE) && !gnt_idx && !reset;
    bus.m1_ack   = (state == DONE) &&  gnt_idx && !reset;
    bus.m0_rdata = rdata0;
    bus.m1_rdata = rdata1;
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed scoreboard bench for gpio_bus_arbiter.
module tb_gpio_bus_arbiter;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    int          cyc;
    logic        idx;
    logic [31:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic prev_cs = 1'b0;

  acc_t acc_q[$];
  ack_t ack_q[$];
  logic [31:0] mem [16];

  gpio_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  gpio_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // GPIO slave model: combinational read, write at the clock edge.
  assign bus.s_rdata = mem[bus.s_addr[5:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h0000_00A5;
    end else if (bus.s_cs && bus.s_wr) begin
      mem[bus.s_addr[5:2]] <= bus.s_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes the slave or acks.
  always @(negedge clk) begin
    if (bus.s_cs === 1'b1) begin
      chk("cs_consecutive", {63'd0, prev_cs}, 64'd0);
      if (acc_q.size() == 0) begin
        chk("unexpected_access", 64'd1, 64'd0);
      end else begin
        acc_t e;
        e = acc_q.pop_front();
        chk("access_cycle", 64'(cyc), 64'(e.cyc));
        chk("access_wr",    {63'd0, bus.s_wr}, {63'd0, e.wr});
        chk("access_addr",  {32'd0, bus.s_addr}, {32'd0, e.addr});
        chk("access_wdata", {32'd0, bus.s_wdata}, {32'd0, e.wdata});
      end
    end
    if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
      chk("ack_exclusive", {63'd0, bus.m0_ack & bus.m1_ack}, 64'd0);
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 64'd1, 64'd0);
      end else begin
        ack_t a;
        a = ack_q.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(a.cyc));
        chk("ack_idx", {63'd0, bus.m1_ack}, {63'd0, a.idx});
        chk("ack_rdata", {32'd0, a.idx ? bus.m1_rdata : bus.m0_rdata}, {32'd0, a.rdata});
      end
    end
    prev_cs = (bus.s_cs === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input int c, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    acc_t e;
    e.cyc = c; e.wr = wr; e.addr = addr; e.wdata = wd;
    acc_q.push_back(e);
  endtask

  task automatic push_ack(input int c, input logic idx, input logic [31:0] rd);
    ack_t a;
    a.cyc = c; a.idx = idx; a.rdata = rd;
    ack_q.push_back(a);
  endtask

  task automatic drive(input logic idx, input logic req, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (idx) begin
      bus.m1_req = req; bus.m1_wr = wr; bus.m1_addr = addr; bus.m1_wdata = wd;
    end else begin
      bus.m0_req = req; bus.m0_wr = wr; bus.m0_addr = addr; bus.m0_wdata = wd;
    end
  endtask

  // Single transaction from IDLE; returns in the IDLE cycle after the ack.
  task automatic txn(input logic idx, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    int n;
    n = cyc;
    drive(idx, 1'b1, wr, addr, wd);
    push_acc(n + 1, wr, addr, wd);
    push_ack(n + 2, idx, exp_rd);
    tick();
    tick();
    drive(idx, 1'b0, wr, addr, wd);
    tick();
  endtask

  initial begin
    int n;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    // Reset state, observed in the cycle right after reset.
    chk("rst_s_cs",  {63'd0, bus.s_cs}, 64'd0);
    chk("rst_s_addr", {32'd0, bus.s_addr}, 64'd0);
    chk("rst_m0_rdata", {32'd0, bus.m0_rdata}, 64'd0);
    tick();

    // 1: m0 write 0xFF to 0x0.
    txn(1'b0, 1'b1, 32'h0, 32'h0000_00FF, 32'h0);

    // 2: m1 read 0x4 -> 0xA5, held after req drops; m0_rdata untouched.
    txn(1'b1, 1'b0, 32'h4, 32'h0, 32'h0000_00A5);
    chk("m0_rdata_untouched", {32'd0, bus.m0_rdata}, 64'd0);
    tick(); tick();
    chk("m1_rdata_hold", {32'd0, bus.m1_rdata}, 64'h0000_00A5);

    // 4: m0 changes fields and drops req during ACCESS; latched values used.
    n = cyc;
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h1234);
    push_acc(n + 1, 1'b1, 32'h10, 32'h1234);
    push_ack(n + 2, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h20, 32'hDEAD);
    tick(); tick(); tick();

    // 5: m0 reads 0x0 (0xFF), reset asserted in DONE kills the ack.
    n = cyc;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    push_acc(n + 1, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rdata_captured", {32'd0, bus.m0_rdata}, 64'h0000_00FF);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    chk("post_rst_cs",     {63'd0, bus.s_cs}, 64'd0);
    chk("post_rst_wr",     {63'd0, bus.s_wr}, 64'd0);
    chk("post_rst_addr",   {32'd0, bus.s_addr}, 64'd0);
    chk("post_rst_wdata",  {32'd0, bus.s_wdata}, 64'd0);
    chk("post_rst_acks",   {62'd0, bus.m1_ack, bus.m0_ack}, 64'd0);
    chk("post_rst_rdata0", {32'd0, bus.m0_rdata}, 64'd0);
    chk("post_rst_rdata1", {32'd0, bus.m1_rdata}, 64'd0);

    // 3: both request continuously from reset: m0, m1, m0, m1.
    n = cyc;
    drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h11);
    drive(1'b1, 1'b1, 1'b1, 32'hC, 32'h22);
    push_acc(n + 1,  1'b1, 32'h8, 32'h11);
    push_acc(n + 4,  1'b1, 32'hC, 32'h22);
    push_acc(n + 7,  1'b1, 32'h8, 32'h11);
    push_acc(n + 10, 1'b1, 32'hC, 32'h22);
    push_ack(n + 2,  1'b0, 32'h0);
    push_ack(n + 5,  1'b1, 32'h0);
    push_ack(n + 8,  1'b0, 32'h0);
    push_ack(n + 11, 1'b1, 32'h0);
    repeat (11) tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // 6: m0 holds req alone: a transaction every 3 cycles.
    n = cyc;
    drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
    for (int k = 0; k < 3; k++) begin
      push_acc(n + 1 + 3 * k, 1'b0, 32'h4, 32'h0);
      push_ack(n + 2 + 3 * k, 1'b0, 32'h0000_00A5);
    end
    repeat (8) tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) tick();

    chk("acc_q_drained", 64'(acc_q.size()), 64'd0);
    chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_bus_arbiter.md
# gpio_bus_arbiter

Two-requester bus arbiter that shares one memory-mapped GPIO peripheral (cs/wr/addr/wdata/rdata slave interface) between the CPU data port (requester 0) and an auxiliary master such as a DMA or pattern sequencer (requester 1). It performs round-robin arbitration, registers the winning request, and drives exactly one single-cycle slave access per transaction. It returns a one-cycle acknowledge with registered read data. It sits between the bus interconnect and the GPIO block; the GPIO's own ports are unchanged.

## Interface

Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1 each: transaction request; held until the matching ack.
- `m0_wr`, `m1_wr`  in  1 each: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  AW each: byte address.
- `m0_wdata`, `m1_wdata`  in  DW each: write data.
- `m0_ack`, `m1_ack`  out  1 each: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DW each: registered read data, valid from the ack cycle.
- `s_cs`  out  1: slave chip select.
- `s_wr`  out  1: slave write strobe.
- `s_addr`  out  AW: slave address.
- `s_wdata`  out  DW: slave write data.
- `s_rdata`  in  DW: slave read data (combinational from `s_addr`).

## Operation

- FSM states are IDLE, ACCESS and DONE. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any `mX_req` asserted: pick a winner, latch its wr/addr/wdata and index into `gnt_idx`, then go to ACCESS.
- Round-robin selection:
  - Register `last` (reset 1, so m0 wins first).
  - Single requester: it wins.
  - Both requesting: the index != `last` wins.
  - `last` <= winner on every grant.
- ACCESS, exactly one cycle:
  - `s_cs`=1, `s_wr`=latched wr, `s_addr`/`s_wdata` = latched values.
  - On a read, capture `s_rdata` into `mX_rdata` of `gnt_idx` at the end of the cycle.
  - Next state is DONE.
- DONE, exactly one cycle: `mX_ack`=1 for `gnt_idx` only. Next state is IDLE.
- Request handling:
  - Requester fields are sampled only at the IDLE→ACCESS edge. Changes afterwards are ignored.
  - Dropping `mX_req` during ACCESS/DONE does not abort; the ack still pulses.
  - The requester must deassert req, or present a new request, in the cycle after ack. A req still high in the following IDLE is a new transaction.
- Write ack: `mX_rdata` is unchanged.
- Read data hold: `mX_rdata` holds its value until that requester's next read completes.
- Outside ACCESS: `s_cs`=0 and `s_wr`=0. `s_addr`/`s_wdata` hold their latched values (no glitch requirement, but deterministic).

## Timing

- Reset values: `s_cs`=0, `s_wr`=0, `s_addr`=0, `s_wdata`=0, `m0_ack`=`m1_ack`=0, `m0_rdata`=`m1_rdata`=0, state=IDLE, `last`=1.
- Latency: req high in cycle N (state IDLE) → ACCESS in N+1 → ack in N+2. The slave write commits at the edge ending N+1.
- Throughput: at most one transaction per 3 cycles. With continuous requests from both masters, grants strictly alternate.
- Reset asserted in ACCESS or DONE:
  - Next cycle is IDLE with all outputs at reset values.
  - No ack is issued for the killed transaction.
  - A write whose ACCESS edge coincides with reset is not guaranteed to commit (the slave also resets).
- Both acks are never high in the same cycle; `s_cs` is never high for two consecutive cycles.

## Structure

- Package `gpio_arb_pkg`: state enum (IDLE, ACCESS, DONE), `RR_RESET_LAST` = 1, default `AW`/`DW`.
- One sub-module: `rr_pick2` (inputs req[1:0] and last; outputs gnt_valid and gnt_idx), purely combinational.
- FSM, latch registers and rdata registers stay in the top module.

## Test plan

1. After reset, m0 writes addr 0x0 data 0x0000_00FF → `s_cs`=`s_wr`=1 for exactly one cycle with `s_addr`=0x0 and `s_wdata`=0xFF, then `m0_ack` pulses 2 cycles after req; `m1_ack` stays 0.
2. m1 reads addr 0x4 while the slave returns 0xA5 → `m1_rdata`=0x0000_00A5 in the ack cycle, held after `m1_req` drops; `m0_rdata` stays 0.
3. m0 and m1 both request in the same cycle from reset, repeatedly → grant order m0, m1, m0, m1; acks 3 cycles apart.
4. m0 changes addr/wdata and drops req during ACCESS → the slave sees the originally latched values; `m0_ack` still pulses once.
5. Reset asserted during DONE → no ack that cycle; next cycle all outputs are at reset values; the next simultaneous request is granted to m0.
6. m0 holds req high continuously with m1 idle → back-to-back transactions every 3 cycles, each acked once.
